// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// lane geometry and the request legality check.
package lsu_pkg;

    // Byte lanes per RAM word and bits per lane
    localparam int NUM_LANES = 4;
    localparam int LANE_BITS = 8;

    // Access size encodings as presented on the size port
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Access FSM states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // A request is dropped when it is both a load and a store, uses the
    // reserved size code, or is not naturally aligned for its size.
    function automatic logic access_is_fault(
        input logic       rd,
        input logic       wr,
        input logic [1:0] sz,
        input logic [1:0] addr_lo
    );
        logic bad;
        bad = 1'b0;
        if (rd && wr) begin
            bad = 1'b1;
        end
        if (sz == SZ_ILLEGAL) begin
            bad = 1'b1;
        end
        if ((sz == SZ_HALF) && addr_lo[0]) begin
            bad = 1'b1;
        end
        if ((sz == SZ_WORD) && (addr_lo != 2'b00)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane steering for stores and lane extraction plus
// sign/zero extension for loads. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]           size,
    input  logic [1:0]           addr_lo,
    input  logic                 load_unsigned,
    input  logic [31:0]          store_data,
    input  logic [31:0]          rdata,
    output logic [NUM_LANES-1:0] be,
    output logic [31:0]          wdata,
    output logic [31:0]          load_ext
);

    logic [LANE_BITS-1:0] rd_lane [NUM_LANES];
    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;
    logic                 byte_sign;
    logic                 half_sign;

    // Split the read word into its byte lanes
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign rd_lane[gi] = rdata[LANE_BITS*gi +: LANE_BITS];
        end
    endgenerate

    assign sel_byte  = rd_lane[addr_lo];
    assign sel_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    assign byte_sign = ~load_unsigned & sel_byte[7];
    assign half_sign = ~load_unsigned & sel_half[15];

    // Store steering: replicate narrow data across lanes, enable only the target lanes
    always_comb begin
        be    = '0;
        wdata = store_data;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                be    = '0;
                wdata = store_data;
            end
        endcase
    end

    // Load extraction: pick the addressed byte/half and extend it to 32 bits
    always_comb begin
        load_ext = rdata;
        case (size)
            SZ_BYTE: load_ext = {{24{byte_sign}}, sel_byte};
            SZ_HALF: load_ext = {{16{half_sign}}, sel_half};
            default: load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Accepts one access at a time from execute,
// stalls the core while the RAM handshake is outstanding, and returns the
// extended load result to writeback. Illegal or misaligned requests are
// reported with a one-cycle fault pulse and never reach the RAM.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                size,
    input  logic                      load_unsigned,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [DATA_WIDTH-1:0]     store_data,
    output logic                      stall,
    output logic [DATA_WIDTH-1:0]     load_data,
    output logic                      load_valid,
    output logic                      access_fault,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [NUM_LANES-1:0]      mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    logic [1:0]                state_reg;
    logic [1:0]                addr_lo_reg;
    logic [1:0]                size_reg;
    logic                      unsigned_reg;
    logic [DATA_WIDTH-1:0]     load_data_reg;
    logic                      load_valid_reg;
    logic                      access_fault_reg;
    logic                      mem_req_reg;
    logic                      mem_we_reg;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_reg;
    logic [NUM_LANES-1:0]      mem_be_reg;
    logic [DATA_WIDTH-1:0]     mem_wdata_reg;

    logic                      in_idle;
    logic                      in_req;
    logic                      start;
    logic                      fault;

    logic [1:0]                align_size;
    logic [1:0]                align_addr_lo;
    logic                      align_unsigned;
    logic [NUM_LANES-1:0]      align_be;
    logic [DATA_WIDTH-1:0]     align_wdata;
    logic [DATA_WIDTH-1:0]     align_load;

    // Address bits above the RAM word index are deliberately discarded
    logic                      unused_addr_bits;
    assign unused_addr_bits = ^alu_result[DATA_WIDTH-1:MEM_ADDR_WIDTH+2];

    assign in_idle = (state_reg == ST_IDLE);
    assign in_req  = (state_reg == ST_REQ);
    assign start   = ex_valid & (mem_read | mem_write);
    assign fault   = access_is_fault(mem_read, mem_write, size, alu_result[1:0]);

    // Core must hold its inputs from the accepting cycle until the access retires
    assign stall = (in_idle & start & ~fault) | in_req;

    // The aligner sees live inputs while steering a new store in IDLE and the
    // captured access attributes while extracting load data in REQ.
    assign align_size     = in_idle ? size          : size_reg;
    assign align_addr_lo  = in_idle ? alu_result[1:0] : addr_lo_reg;
    assign align_unsigned = in_idle ? load_unsigned : unsigned_reg;

    lsu_align u_align (
        .size          (align_size),
        .addr_lo       (align_addr_lo),
        .load_unsigned (align_unsigned),
        .store_data    (store_data),
        .rdata         (mem_rdata),
        .be            (align_be),
        .wdata         (align_wdata),
        .load_ext      (align_load)
    );

    // Access FSM with its captured request and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            addr_lo_reg      <= '0;
            size_reg         <= '0;
            unsigned_reg     <= 1'b0;
            load_data_reg    <= '0;
            load_valid_reg   <= 1'b0;
            access_fault_reg <= 1'b0;
            mem_req_reg      <= 1'b0;
            mem_we_reg       <= 1'b0;
            mem_addr_reg     <= '0;
            mem_be_reg       <= '0;
            mem_wdata_reg    <= '0;
        end else begin
            load_valid_reg   <= 1'b0;
            access_fault_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (fault) begin
                            access_fault_reg <= 1'b1;
                        end else begin
                            state_reg     <= ST_REQ;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= mem_write;
                            mem_addr_reg  <= alu_result[MEM_ADDR_WIDTH+1:2];
                            mem_be_reg    <= align_be;
                            mem_wdata_reg <= align_wdata;
                            addr_lo_reg   <= alu_result[1:0];
                            size_reg      <= size;
                            unsigned_reg  <= load_unsigned;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        if (!mem_we_reg) begin
                            load_data_reg  <= align_load;
                            load_valid_reg <= 1'b1;
                        end
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_data    = load_data_reg;
    assign load_valid   = load_valid_reg;
    assign access_fault = access_fault_reg;
    assign mem_req      = mem_req_reg;
    assign mem_we       = mem_we_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_be       = mem_be_reg;
    assign mem_wdata    = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed and random
// accesses and queues the expected outcome from a word-array reference model;
// a monitor pops and compares whenever the DUT handshakes, faults or returns
// load data. A behavioural RAM answers the memory port with random latency.
module tb_load_store_unit;

    localparam int K_FAULT = 0;
    localparam int K_STORE = 1;
    localparam int K_LOAD  = 2;

    typedef struct {
        int          kind;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_fault;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    exp_t        sb[$];
    logic [31:0] ram     [1024];
    logic [31:0] ref_mem [1024];
    int          ready_wait  = 0;
    bit          force_ready = 1'b0;
    int          wait_cnt    = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_WIDTH     (32),
        .MEM_ADDR_WIDTH (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .size          (size),
        .load_unsigned (load_unsigned),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .stall         (stall),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .access_fault  (access_fault),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural RAM: answers a pending request after ready_wait cycles
    always @(negedge clk) begin
        mem_rdata = ram[mem_addr];
        if (mem_req) begin
            if (force_ready || wait_cnt >= ready_wait) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = force_ready;
            wait_cnt  = 0;
        end
    end

    // Monitor: match every DUT-side event against the head of the scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                if (mem_req && mem_ready) begin
                    if (sb.size() != 0 && sb[0].kind == K_STORE) begin
                        e = sb.pop_front();
                        check32("store_mem_we", 32'(mem_we), 32'd1);
                        check32("store_mem_addr", 32'(mem_addr), 32'(e.addr));
                        check32("store_mem_be", 32'(mem_be), 32'(e.be));
                        check32("store_mem_wdata", mem_wdata, e.wdata);
                        $display("store addr=%h be=%b wdata=%h", mem_addr, mem_be, mem_wdata);
                    end else if (sb.size() != 0 && sb[0].kind == K_LOAD) begin
                        check32("load_mem_we", 32'(mem_we), 32'd0);
                        check32("load_mem_addr", 32'(mem_addr), 32'(sb[0].addr));
                    end else begin
                        check32("mem_req_unexpected", 32'(mem_req), 32'd0);
                    end
                end
                if (load_valid) begin
                    if (sb.size() != 0 && sb[0].kind == K_LOAD) begin
                        e = sb.pop_front();
                        check32("load_data", load_data, e.data);
                        $display("load  addr=%h data=%h", e.addr, load_data);
                    end else begin
                        check32("load_valid_unexpected", 32'(load_valid), 32'd0);
                    end
                end
                if (access_fault) begin
                    if (sb.size() != 0 && sb[0].kind == K_FAULT) begin
                        e = sb.pop_front();
                        check32("fault_no_mem_req", 32'(mem_req), 32'd0);
                        $display("fault dropped request");
                    end else begin
                        check32("access_fault_unexpected", 32'(access_fault), 32'd0);
                    end
                end
            end
        end
    end

    // Issue one access, queue its expected outcome, and measure the stall length
    task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] d, input int w);
        exp_t        e;
        bit          flt;
        int          idx;
        int          sh;
        int          cnt;
        int          guard;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] v;

        flt = (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        idx = int'((a / 4) % 1024);
        sh  = int'(8 * (a % 4));
        e.addr  = 10'(idx);
        e.be    = 4'h0;
        e.wdata = 32'h0;
        e.data  = 32'h0;
        if (flt) begin
            e.kind = K_FAULT;
        end else if (wr) begin
            e.kind = K_STORE;
            case (sz)
                2'd0: begin
                    e.be = 4'(1 << (a % 4)); e.wdata = (d & 32'hFF) * 32'h0101_0101; mask = 32'hFF << sh;
                end
                2'd1: begin
                    e.be = 4'(3 << (a % 4)); e.wdata = (d & 32'hFFFF) * 32'h0001_0001; mask = 32'hFFFF << sh;
                end
                default: begin
                    e.be = 4'hF; e.wdata = d; mask = 32'hFFFF_FFFF;
                end
            endcase
            ref_mem[idx] = (ref_mem[idx] & ~mask) | ((d << sh) & mask);
        end else begin
            e.kind = K_LOAD;
            word = ref_mem[idx];
            case (sz)
                2'd0: begin
                    v = (word >> sh) & 32'hFF;
                    if (!uns && v >= 128) v = v - 256;
                end
                2'd1: begin
                    v = (word >> sh) & 32'hFFFF;
                    if (!uns && v >= 32768) v = v - 65536;
                end
                default: v = word;
            endcase
            e.data = v;
        end
        sb.push_back(e);
        ready_wait = w;

        @(negedge clk);
        ex_valid      = 1'b1;
        mem_read      = rd;
        mem_write     = wr;
        size          = sz;
        load_unsigned = uns;
        alu_result    = a;
        store_data    = d;
        #1;
        cnt   = 0;
        guard = 0;
        while (stall && guard < 200) begin
            cnt++;
            guard++;
            @(negedge clk);
            #1;
        end
        if (guard >= 200) begin
            check32("stall_timeout", 32'(stall), 32'd0);
        end
        check32("stall_cycles", 32'(cnt), flt ? 32'd0 : 32'(2 + w));
        if (flt) begin
            @(negedge clk);
        end
        ex_valid  = 1'b0;
        mem_read  = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [31:0] v;
        logic [31:0] a;
        int          r;
        logic [1:0]  sz;
        bit          rd;
        bit          wr;

        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            ram[i]     = v;
            ref_mem[i] = v;
        end
        rst = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        size = 2'b00; load_unsigned = 1'b0; alu_result = 32'h0; store_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check32("rst_stall", 32'(stall), 32'd0);
        check32("rst_load_data", load_data, 32'd0);
        check32("rst_load_valid", 32'(load_valid), 32'd0);
        check32("rst_access_fault", 32'(access_fault), 32'd0);
        check32("rst_mem_req", 32'(mem_req), 32'd0);
        check32("rst_mem_we", 32'(mem_we), 32'd0);
        check32("rst_mem_addr", 32'(mem_addr), 32'd0);
        check32("rst_mem_be", 32'(mem_be), 32'd0);
        check32("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;

        // Directed accesses
        ram[4] = 32'h80FF_FF7F; ref_mem[4] = 32'h80FF_FF7F;
        issue(1, 0, 2'd0, 0, 32'h0000_0013, 32'h0, 3);
        issue(0, 1, 2'd2, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        ram[0] = 32'h8001_1234; ref_mem[0] = 32'h8001_1234;
        issue(1, 0, 2'd1, 1, 32'h0000_0002, 32'h0, 1);
        issue(1, 0, 2'd1, 0, 32'h0000_0002, 32'h0, 0);
        issue(0, 1, 2'd0, 0, 32'h0000_0005, 32'h0000_00AB, 0);
        issue(0, 1, 2'd0, 0, 32'h0000_1004, 32'h0000_00AB, 2);
        issue(1, 0, 2'd1, 1, 32'h0000_1004, 32'h0, 0);
        issue(1, 0, 2'd2, 0, 32'h0000_0006, 32'h0, 0);
        issue(1, 0, 2'd3, 0, 32'h0000_0008, 32'h0, 0);
        issue(1, 1, 2'd2, 0, 32'h0000_0008, 32'h1234_5678, 0);

        // Reset during an outstanding request
        ready_wait = 100000;
        @(negedge clk);
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2;
        load_unsigned = 1'b0; alu_result = 32'h0000_0020;
        repeat (3) @(negedge clk);
        #1;
        check32("rst_mid_req_pending", 32'(mem_req), 32'd1);
        rst = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        #1;
        check32("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check32("rst_mid_stall", 32'(stall), 32'd0);
        rst = 1'b1;
        force_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check32("rst_mid_no_load_valid", 32'(load_valid), 32'd0);
        end
        force_ready = 1'b0;
        ready_wait  = 0;
        $display("reset during request abandoned transfer");

        // Random accesses, including wrap-around high address bits
        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 9);
            rd = (r <= 5);
            wr = (r == 0) || (r > 5);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            issue(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 4));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check32("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
